// File: rtl/axi4_pkg.sv
// axi4_pkg: AXI4 response/burst encodings and arbiter grant states shared by the read and write arbiters
package axi4_pkg;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  typedef enum logic [1:0] {
    GNT_IDLE = 2'b00,
    GNT_M0   = 2'b01,
    GNT_M1   = 2'b10
  } gnt_e;
endpackage

// File: rtl/fixed_prio_arb.sv
// fixed_prio_arb: one-hot grant to the lowest-index active request
module fixed_prio_arb #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  assign gnt = req & -req;
endmodule

// File: rtl/arbiter_axi_4_w.sv
// arbiter_axi_4_w: two-master fixed-priority AXI4 write arbiter (AW/W/B), one transaction in flight
module arbiter_axi_4_w
  import axi4_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_ID_WIDTH-1:0]   M0_AXI_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0] M0_AXI_AWADDR,
  input  logic [7:0]                M0_AXI_AWLEN,
  input  logic [2:0]                M0_AXI_AWSIZE,
  input  logic [1:0]                M0_AXI_AWBURST,
  input  logic                      M0_AXI_AWLOCK,
  input  logic [3:0]                M0_AXI_AWCACHE,
  input  logic [2:0]                M0_AXI_AWPROT,
  input  logic [3:0]                M0_AXI_AWQOS,
  input  logic [3:0]                M0_AXI_AWREGION,
  input  logic [AXI_USER_WIDTH-1:0] M0_AXI_AWUSER,
  input  logic                      M0_AXI_AWVALID,
  output logic                      M0_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0] M0_AXI_WDATA,
  input  logic [AXI_STRB_WIDTH-1:0] M0_AXI_WSTRB,
  input  logic                      M0_AXI_WLAST,
  input  logic [AXI_USER_WIDTH-1:0] M0_AXI_WUSER,
  input  logic                      M0_AXI_WVALID,
  output logic                      M0_AXI_WREADY,
  output logic [AXI_ID_WIDTH-1:0]   M0_AXI_BID,
  output logic [1:0]                M0_AXI_BRESP,
  output logic [AXI_USER_WIDTH-1:0] M0_AXI_BUSER,
  output logic                      M0_AXI_BVALID,
  input  logic                      M0_AXI_BREADY,
  input  logic [AXI_ID_WIDTH-1:0]   M1_AXI_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0] M1_AXI_AWADDR,
  input  logic [7:0]                M1_AXI_AWLEN,
  input  logic [2:0]                M1_AXI_AWSIZE,
  input  logic [1:0]                M1_AXI_AWBURST,
  input  logic                      M1_AXI_AWLOCK,
  input  logic [3:0]                M1_AXI_AWCACHE,
  input  logic [2:0]                M1_AXI_AWPROT,
  input  logic [3:0]                M1_AXI_AWQOS,
  input  logic [3:0]                M1_AXI_AWREGION,
  input  logic [AXI_USER_WIDTH-1:0] M1_AXI_AWUSER,
  input  logic                      M1_AXI_AWVALID,
  output logic                      M1_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0] M1_AXI_WDATA,
  input  logic [AXI_STRB_WIDTH-1:0] M1_AXI_WSTRB,
  input  logic                      M1_AXI_WLAST,
  input  logic [AXI_USER_WIDTH-1:0] M1_AXI_WUSER,
  input  logic                      M1_AXI_WVALID,
  output logic                      M1_AXI_WREADY,
  output logic [AXI_ID_WIDTH-1:0]   M1_AXI_BID,
  output logic [1:0]                M1_AXI_BRESP,
  output logic [AXI_USER_WIDTH-1:0] M1_AXI_BUSER,
  output logic                      M1_AXI_BVALID,
  input  logic                      M1_AXI_BREADY,
  output logic [AXI_ID_WIDTH-1:0]   S_AXI_AWID,
  output logic [AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  output logic [7:0]                S_AXI_AWLEN,
  output logic [2:0]                S_AXI_AWSIZE,
  output logic [1:0]                S_AXI_AWBURST,
  output logic                      S_AXI_AWLOCK,
  output logic [3:0]                S_AXI_AWCACHE,
  output logic [2:0]                S_AXI_AWPROT,
  output logic [3:0]                S_AXI_AWQOS,
  output logic [3:0]                S_AXI_AWREGION,
  output logic [AXI_USER_WIDTH-1:0] S_AXI_AWUSER,
  output logic                      S_AXI_AWVALID,
  input  logic                      S_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  output logic [AXI_STRB_WIDTH-1:0] S_AXI_WSTRB,
  output logic                      S_AXI_WLAST,
  output logic [AXI_USER_WIDTH-1:0] S_AXI_WUSER,
  output logic                      S_AXI_WVALID,
  input  logic                      S_AXI_WREADY,
  input  logic [AXI_ID_WIDTH-1:0]   S_AXI_BID,
  input  logic [1:0]                S_AXI_BRESP,
  input  logic [AXI_USER_WIDTH-1:0] S_AXI_BUSER,
  input  logic                      S_AXI_BVALID,
  output logic                      S_AXI_BREADY
);
  localparam int AWW = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 29 + AXI_USER_WIDTH;
  localparam int WW  = AXI_DATA_WIDTH + AXI_STRB_WIDTH + 1 + AXI_USER_WIDTH;
  localparam int BW  = AXI_ID_WIDTH + 2 + AXI_USER_WIDTH;
  gnt_e grant;
  logic [1:0] nxt;
  logic aw_done, w_done, g0, g1;
  logic [AWW-1:0] m0_aw, m1_aw;
  logic [WW-1:0] m0_w, m1_w;
  logic [BW-1:0] s_b;
  assign g0 = grant == GNT_M0;
  assign g1 = grant == GNT_M1;
  fixed_prio_arb #(.N(2)) u_arb (
    .req({M1_AXI_AWVALID | M1_AXI_WVALID, M0_AXI_AWVALID | M0_AXI_WVALID}),
    .gnt(nxt)
  );
  assign m0_aw = {M0_AXI_AWID, M0_AXI_AWADDR, M0_AXI_AWLEN, M0_AXI_AWSIZE, M0_AXI_AWBURST, M0_AXI_AWLOCK,
                  M0_AXI_AWCACHE, M0_AXI_AWPROT, M0_AXI_AWQOS, M0_AXI_AWREGION, M0_AXI_AWUSER};
  assign m1_aw = {M1_AXI_AWID, M1_AXI_AWADDR, M1_AXI_AWLEN, M1_AXI_AWSIZE, M1_AXI_AWBURST, M1_AXI_AWLOCK,
                  M1_AXI_AWCACHE, M1_AXI_AWPROT, M1_AXI_AWQOS, M1_AXI_AWREGION, M1_AXI_AWUSER};
  assign m0_w = {M0_AXI_WDATA, M0_AXI_WSTRB, M0_AXI_WLAST, M0_AXI_WUSER};
  assign m1_w = {M1_AXI_WDATA, M1_AXI_WSTRB, M1_AXI_WLAST, M1_AXI_WUSER};
  assign s_b = {S_AXI_BID, S_AXI_BRESP, S_AXI_BUSER};
  assign {S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK, S_AXI_AWCACHE,
          S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION, S_AXI_AWUSER} = g0 ? m0_aw : g1 ? m1_aw : '0;
  assign {S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WUSER} = g0 ? m0_w : g1 ? m1_w : '0;
  assign S_AXI_AWVALID = (g0 & M0_AXI_AWVALID | g1 & M1_AXI_AWVALID) & ~aw_done;
  assign S_AXI_WVALID = (g0 & M0_AXI_WVALID | g1 & M1_AXI_WVALID) & ~w_done;
  assign S_AXI_BREADY = g0 & M0_AXI_BREADY | g1 & M1_AXI_BREADY;
  assign M0_AXI_AWREADY = g0 & S_AXI_AWREADY & ~aw_done;
  assign M1_AXI_AWREADY = g1 & S_AXI_AWREADY & ~aw_done;
  assign M0_AXI_WREADY = g0 & S_AXI_WREADY & ~w_done;
  assign M1_AXI_WREADY = g1 & S_AXI_WREADY & ~w_done;
  assign M0_AXI_BVALID = g0 & S_AXI_BVALID;
  assign M1_AXI_BVALID = g1 & S_AXI_BVALID;
  assign {M0_AXI_BID, M0_AXI_BRESP, M0_AXI_BUSER} = g0 ? s_b : '0;
  assign {M1_AXI_BID, M1_AXI_BRESP, M1_AXI_BUSER} = g1 ? s_b : '0;
  // a B handshake only releases once both address and last data beat have been accepted
  always_ff @(posedge clk) begin
    if (rst || !(g0 || g1 || grant == GNT_IDLE)) begin
      grant <= GNT_IDLE;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else if (grant == GNT_IDLE || (S_AXI_BVALID && S_AXI_BREADY && aw_done && w_done)) begin
      grant <= gnt_e'(nxt);
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done <= 1'b1;
      if (S_AXI_WVALID && S_AXI_WREADY && S_AXI_WLAST) w_done <= 1'b1;
    end
  end
endmodule

// File: tb/tb_arbiter_axi_4_w.sv
// tb_arbiter_axi_4_w: vector table, directed corner sequences and random traffic against an ownership model
module tb_arbiter_axi_4_w;
  import axi4_pkg::*;
  typedef struct packed {
    logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
    logic lock; logic [3:0] cache; logic [2:0] prot; logic [3:0] qos; logic [3:0] region; logic user;
  } aw_t;
  typedef struct packed {logic [63:0] data; logic [7:0] strb; logic last; logic user;} w_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp; logic user;} b_t;
  typedef struct packed {
    aw_t saw; logic sawv; logic [1:0] awrdy; w_t sw; logic swv; logic [1:0] wrdy;
    b_t [1:0] mb; logic [1:0] bv; logic sbrdy;
  } out_t;
  typedef struct packed {
    logic r; logic [1:0] awv, wv, brdy; logic sa, sw, sb, wl;
    logic [1:0] e_awrdy, e_wrdy, e_bv; logic e_sawv, e_swv, e_sbrdy;
  } vec_t;
  logic clk = 1'b0, rst;
  aw_t aw[2];
  w_t w[2];
  b_t sb, mb0, mb1;
  logic [1:0] awv, wv, brdy, awrdy, wrdy, bv;
  logic s_awrdy, s_wrdy, s_bv, s_awv, s_wv, s_brdy;
  aw_t s_aw;
  w_t s_w;
  out_t act;
  int checks = 0, errors = 0;
  int own;
  logic awd, wd, hs_w;
  vec_t tbl[13];
  logic [63:0] dat[4];
  logic [64:0] wq[$];
  always #5 clk = ~clk;
  arbiter_axi_4_w dut (
    .clk(clk), .rst(rst),
    .M0_AXI_AWID(aw[0].id), .M0_AXI_AWADDR(aw[0].addr), .M0_AXI_AWLEN(aw[0].len), .M0_AXI_AWSIZE(aw[0].size),
    .M0_AXI_AWBURST(aw[0].burst), .M0_AXI_AWLOCK(aw[0].lock), .M0_AXI_AWCACHE(aw[0].cache),
    .M0_AXI_AWPROT(aw[0].prot), .M0_AXI_AWQOS(aw[0].qos), .M0_AXI_AWREGION(aw[0].region),
    .M0_AXI_AWUSER(aw[0].user), .M0_AXI_AWVALID(awv[0]), .M0_AXI_AWREADY(awrdy[0]),
    .M0_AXI_WDATA(w[0].data), .M0_AXI_WSTRB(w[0].strb), .M0_AXI_WLAST(w[0].last), .M0_AXI_WUSER(w[0].user),
    .M0_AXI_WVALID(wv[0]), .M0_AXI_WREADY(wrdy[0]),
    .M0_AXI_BID(mb0.id), .M0_AXI_BRESP(mb0.resp), .M0_AXI_BUSER(mb0.user), .M0_AXI_BVALID(bv[0]),
    .M0_AXI_BREADY(brdy[0]),
    .M1_AXI_AWID(aw[1].id), .M1_AXI_AWADDR(aw[1].addr), .M1_AXI_AWLEN(aw[1].len), .M1_AXI_AWSIZE(aw[1].size),
    .M1_AXI_AWBURST(aw[1].burst), .M1_AXI_AWLOCK(aw[1].lock), .M1_AXI_AWCACHE(aw[1].cache),
    .M1_AXI_AWPROT(aw[1].prot), .M1_AXI_AWQOS(aw[1].qos), .M1_AXI_AWREGION(aw[1].region),
    .M1_AXI_AWUSER(aw[1].user), .M1_AXI_AWVALID(awv[1]), .M1_AXI_AWREADY(awrdy[1]),
    .M1_AXI_WDATA(w[1].data), .M1_AXI_WSTRB(w[1].strb), .M1_AXI_WLAST(w[1].last), .M1_AXI_WUSER(w[1].user),
    .M1_AXI_WVALID(wv[1]), .M1_AXI_WREADY(wrdy[1]),
    .M1_AXI_BID(mb1.id), .M1_AXI_BRESP(mb1.resp), .M1_AXI_BUSER(mb1.user), .M1_AXI_BVALID(bv[1]),
    .M1_AXI_BREADY(brdy[1]),
    .S_AXI_AWID(s_aw.id), .S_AXI_AWADDR(s_aw.addr), .S_AXI_AWLEN(s_aw.len), .S_AXI_AWSIZE(s_aw.size),
    .S_AXI_AWBURST(s_aw.burst), .S_AXI_AWLOCK(s_aw.lock), .S_AXI_AWCACHE(s_aw.cache),
    .S_AXI_AWPROT(s_aw.prot), .S_AXI_AWQOS(s_aw.qos), .S_AXI_AWREGION(s_aw.region),
    .S_AXI_AWUSER(s_aw.user), .S_AXI_AWVALID(s_awv), .S_AXI_AWREADY(s_awrdy),
    .S_AXI_WDATA(s_w.data), .S_AXI_WSTRB(s_w.strb), .S_AXI_WLAST(s_w.last), .S_AXI_WUSER(s_w.user),
    .S_AXI_WVALID(s_wv), .S_AXI_WREADY(s_wrdy),
    .S_AXI_BID(sb.id), .S_AXI_BRESP(sb.resp), .S_AXI_BUSER(sb.user), .S_AXI_BVALID(s_bv),
    .S_AXI_BREADY(s_brdy)
  );
  always_comb begin
    act = '0;
    act.saw = s_aw;
    act.sawv = s_awv;
    act.awrdy = awrdy;
    act.sw = s_w;
    act.swv = s_wv;
    act.wrdy = wrdy;
    act.mb[0] = mb0;
    act.mb[1] = mb1;
    act.bv = bv;
    act.sbrdy = s_brdy;
  end
  function automatic aw_t rnd_aw();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[$bits(aw_t)-1:0];
  endfunction
  function automatic w_t rnd_w();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[$bits(w_t)-1:0];
  endfunction
  function automatic b_t rnd_b();
    logic [31:0] t;
    t = $urandom;
    return t[$bits(b_t)-1:0];
  endfunction
  // whoever owns the slave sees it through a transparent wire; everyone else sees zeros
  function automatic out_t exp_f();
    out_t e;
    e = '0;
    if (own >= 0) begin
      e.saw = aw[own];
      e.sawv = awv[own] & ~awd;
      e.awrdy[own] = s_awrdy & ~awd;
      e.sw = w[own];
      e.swv = wv[own] & ~wd;
      e.wrdy[own] = s_wrdy & ~wd;
      e.mb[own] = sb;
      e.bv[own] = s_bv;
      e.sbrdy = brdy[own];
    end
    return e;
  endfunction
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s t=%0t act=%h exp=%h", n, $time, a, x);
    end
  endtask
  task automatic look();
    @(negedge clk);
    chk("model", act, exp_f());
  endtask
  task automatic adv();
    out_t e;
    @(posedge clk);
    e = exp_f();
    hs_w = e.swv & s_wrdy;
    if (rst) begin
      own = -1; awd = 0; wd = 0;
    end else if (own < 0 || (e.sbrdy & s_bv & awd & wd)) begin
      own = (awv[0] | wv[0]) ? 0 : (awv[1] | wv[1]) ? 1 : -1;
      awd = 0; wd = 0;
    end else begin
      if (e.sawv & s_awrdy) awd = 1;
      if (e.swv & s_wrdy & e.sw.last) wd = 1;
    end
    #1;
  endtask
  task automatic tick();
    look();
    adv();
  endtask
  task automatic clr();
    awv = 0; wv = 0; brdy = 0; s_awrdy = 0; s_wrdy = 0; s_bv = 0;
    aw[0] = '0; aw[1] = '0; w[0] = '0; w[1] = '0; sb = '0;
  endtask
  task automatic do_reset();
    rst = 1; clr();
    tick();
    rst = 0;
  endtask
  initial begin
    rst = 1; clr(); own = -1; awd = 0; wd = 0; hs_w = 0;
    @(posedge clk); #1;
    tbl[0]  = {1'b1, 2'b11, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = {1'b0, 2'b11, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = {1'b0, 2'b11, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    tbl[3]  = {1'b0, 2'b10, 2'b01, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1};
    tbl[4]  = {1'b0, 2'b10, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[5]  = {1'b0, 2'b10, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    tbl[6]  = {1'b0, 2'b10, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    tbl[7]  = {1'b0, 2'b00, 2'b10, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1};
    tbl[8]  = {1'b0, 2'b00, 2'b10, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1};
    tbl[9]  = {1'b0, 2'b01, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1};
    tbl[10] = {1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[11] = {1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[12] = {1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].r; awv = tbl[i].awv; wv = tbl[i].wv; brdy = tbl[i].brdy;
      s_awrdy = tbl[i].sa; s_wrdy = tbl[i].sw; s_bv = tbl[i].sb; sb = rnd_b();
      for (int m = 0; m < 2; m++) begin
        aw[m] = rnd_aw(); w[m] = rnd_w(); w[m].last = tbl[i].wl;
      end
      look();
      chk($sformatf("tbl%0d", i), {awrdy, wrdy, bv, s_awv, s_wv, s_brdy},
          {tbl[i].e_awrdy, tbl[i].e_wrdy, tbl[i].e_bv, tbl[i].e_sawv, tbl[i].e_swv, tbl[i].e_sbrdy});
      adv();
    end
    // M0 single-beat write with fixed payload
    do_reset();
    aw[0].addr = 32'h8000_0000; aw[0].size = 3'd3; aw[0].burst = AXI_BURST_INCR;
    w[0].data = 64'h1122334455667788; w[0].strb = 8'hFF; w[0].last = 1;
    awv[0] = 1; wv[0] = 1; s_awrdy = 1; s_wrdy = 1; brdy[0] = 1;
    tick();
    look();
    chk("t2_s_aw", {s_awv, s_aw.addr, s_aw.len}, {1'b1, 32'h8000_0000, 8'd0});
    chk("t2_s_w", {s_wv, s_w.data, s_w.strb, s_w.last}, {1'b1, 64'h1122334455667788, 8'hFF, 1'b1});
    adv();
    awv[0] = 0; wv[0] = 0; s_bv = 1; sb.id = 4'd3; sb.resp = AXI_RESP_OKAY;
    look();
    chk("t2_b", {bv[0], mb0.id, mb0.resp}, {1'b1, 4'd3, AXI_RESP_OKAY});
    chk("t2_m1_quiet", {awrdy[1], wrdy[1], bv[1], mb1}, 0);
    adv();
    s_bv = 0;
    tick();
    // simultaneous requests: M0 first, M1 granted straight after M0's B handshake
    do_reset();
    aw[0] = rnd_aw(); aw[1] = rnd_aw(); w[0] = rnd_w(); w[1] = rnd_w(); w[0].last = 1; w[1].last = 1;
    awv = 2'b11; wv = 2'b11; s_awrdy = 1; s_wrdy = 1; brdy = 2'b11;
    tick();
    look();
    chk("t3_m0_first", {awrdy, wrdy}, {2'b01, 2'b01});
    adv();
    awv[0] = 0; wv[0] = 0; s_bv = 1;
    look();
    chk("t3_m1_wait", {awrdy[1], wrdy[1], bv[1]}, 0);
    adv();
    s_bv = 0; s_awrdy = 0;
    look();
    chk("t3_m1_next", {s_awv, s_aw}, {1'b1, aw[1]});
    adv();
    // M1 burst, W ahead of AW, toggling WREADY, re-asserted AW masked until release
    do_reset();
    aw[1] = rnd_aw(); aw[1].len = 8'd3; w[1] = rnd_w(); w[1].last = 0; wv[1] = 1; brdy[1] = 1;
    for (int k = 0; k < 4; k++) dat[k] = {$urandom, $urandom};
    tick();
    tick();
    awv[1] = 1; s_awrdy = 1; wq.delete();
    for (int k = 0; k < 4; k++) begin
      w[1].data = dat[k]; w[1].last = (k == 3);
      if (k == 1) aw[1].addr = aw[1].addr + 32'h100;
      do begin
        s_wrdy = ~s_wrdy;
        look();
        if (s_wv && s_wrdy) wq.push_back({s_w.data, s_w.last});
        if (k > 0) chk("t4_aw_mask", s_awv, 0);
        adv();
      end while (!hs_w);
    end
    wv[1] = 0;
    chk("t4_nbeats", wq.size(), 4);
    for (int k = 0; k < 4; k++) chk($sformatf("t4_beat%0d", k), (wq.size() > k) ? wq[k] : '1, {dat[k], k == 3});
    s_bv = 1;
    look();
    chk("t4_aw_mask_b", s_awv, 0);
    adv();
    s_bv = 0;
    look();
    chk("t4_aw_release", {s_awv, s_aw.addr}, {1'b1, aw[1].addr});
    adv();
    // reset in the middle of an M0 burst, then a clean M0 write
    do_reset();
    aw[0] = rnd_aw(); aw[0].len = 8'd3; w[0] = rnd_w(); w[0].last = 0;
    awv[0] = 1; wv[0] = 1; s_awrdy = 1; s_wrdy = 1; brdy[0] = 1;
    tick();
    tick();
    awv[0] = 0; w[0].data = {$urandom, $urandom};
    tick();
    rst = 1;
    tick();
    rst = 0; aw[0].len = 0; w[0].last = 1; awv[0] = 1; wv[0] = 1;
    look();
    chk("t6_idle", act, 0);
    adv();
    tick();
    awv[0] = 0; wv[0] = 0; s_bv = 1; sb = rnd_b(); sb.resp = AXI_RESP_OKAY;
    look();
    chk("t6_b", {bv[0], mb0.resp, mb0.id}, {1'b1, AXI_RESP_OKAY, sb.id});
    adv();
    s_bv = 0;
    tick();
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      awv = 2'($urandom); wv = 2'($urandom); brdy = 2'($urandom);
      s_awrdy = 1'($urandom); s_wrdy = 1'($urandom); s_bv = 1'($urandom);
      for (int m = 0; m < 2; m++) begin
        aw[m] = rnd_aw(); w[m] = rnd_w();
      end
      sb = rnd_b();
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
